mac_accum_stage: RTL and testbench
==================================

// Module: mac_accum_stage
// PURPOSE
//  Multiply-accumulate stage built around the team's 4-bit combinational array multiplier.
//  Accepts a burst of 4-bit operand pairs over a valid/ready handshake and sums their 8-bit
//  products into an ACC_W-bit accumulator. A beat flagged in_last closes the burst, and the
//  block then presents the sum downstream on a valid/ready handshake.
// PARAMETERS
//  ACC_W  12  accumulator/result width in bits; must be >= 8
//  CNT_W  4   beat-counter width; the counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      stage can accept a beat
//  in_a       in   4      multiplicand, unsigned
//  in_b       in   4      multiplier, unsigned
//  in_last    in   1      beat is final of burst
//  out_valid  out  1      out_acc/out_cnt/out_ovf valid
//  out_ready  in   1      downstream accepts result
//  out_acc    out  ACC_W  accumulated sum of products
//  out_cnt    out  CNT_W  number of beats in burst
//  out_ovf    out  1      sticky: accumulator overflowed during burst
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high (rst). Reset forces state=IDLE,
//    acc=0, cnt=0, ovf=0, op regs=0, p_vld=0, out_valid=0. in_ready=1 after reset.
//  - Beat accepted on an edge where in_valid && in_ready. At that edge, in_a/in_b/in_last
//    are registered and p_vld is set. The multiplier computes from the registered operands.
//  - On the next edge, acc += product (8-bit, zero-extended to ACC_W) and cnt++ (saturating).
//  - Back-to-back beats are allowed at 1 beat/clk. The accumulate of beat N and the capture of
//    beat N+1 happen on the same edge. Bubbles (in_valid=0) leave acc unchanged.
//  - FSM states: IDLE, ACCUM, FLUSH, DONE.
//    IDLE : in_ready=1. Accepting a non-last beat -> ACCUM. Accepting a last beat -> FLUSH.
//    ACCUM: in_ready=1. Accepting a last beat -> FLUSH. Otherwise stay in ACCUM.
//    FLUSH: in_ready=0. The final product is added on this edge; unconditionally -> DONE.
//    DONE : in_ready=0, out_valid=1. Outputs are held stable until out_ready=1.
//           On the out_ready edge -> IDLE, with acc/cnt/ovf cleared on the same edge.
//  - Latency: out_valid rises 2 edges after the last beat is accepted.
//  - The burst result always includes every accepted beat. No beat is lost or counted twice.
//  - out_acc/out_cnt/out_ovf mirror the internal registers at all times. They are only
//    meaningful while out_valid=1.
//  - Overflow: ovf is set when an add would exceed 2^ACC_W-1, and stays set until DONE
//    completes. The value written into acc is set by CONFIGURATION.
//  - rst asserted mid-burst or in DONE: the partial burst is discarded with no output.
// CONFIGURATION
//  MAC_SATURATE_EN
//    defined    : on overflow, acc clamps to all-ones and further adds hold all-ones.
//    not defined: acc wraps modulo 2^ACC_W.
//    Both modes : ovf is set on overflow.
// STRUCTURE
//  - Package mac_pkg: state enum typedef {IDLE,ACCUM,FLUSH,DONE}; OP_W=4, PROD_W=8 constants.
//  - Sub-module: 4-bit array multiplier arrmultip (inp1, inp2, product[7:0]). Instantiated
//    once and fed from the operand registers.
//  - The FSM, accumulator and counter live in this module.
// TESTING (ACC_W=12, CNT_W=4)
//  1. Burst (10,12),(13,12 last), back-to-back -> out_acc=276, out_cnt=2, out_ovf=0;
//     out_valid rises 2 clk after the last beat.
//  2. Single beat (15,15,last) -> out_acc=225, out_cnt=1; in_ready=0 in FLUSH/DONE.
//  3. 19 beats of (15,15), last on 19th -> wrap build: out_acc=179, out_ovf=1,
//     out_cnt=15 (saturated); MAC_SATURATE_EN build: out_acc=4095, out_ovf=1.
//  4. out_ready held low 5 clk in DONE -> outputs stable, in_valid ignored.
//     On release -> IDLE, a new burst (2,3 last) gives out_acc=6.
//  5. Bubbles: (1,1),gap,gap,(2,2),gap,(3,3 last) -> out_acc=14, out_cnt=3.
//  6. rst pulsed mid-burst after (7,7) -> all outputs 0, in_ready=1;
//     next burst (1,1 last) gives out_acc=1, out_cnt=1.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and operand/product widths for the MAC stage
// Contents: state_t {IDLE, ACCUM, FLUSH, DONE}; OP_W (operand width); PROD_W (product width)
package mac_pkg;
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
endpackage

// File: rtl/arrmultip.sv
// arrmultip: combinational unsigned array multiplier, OP_W x OP_W -> PROD_W
// Ports: inp1 (multiplicand), inp2 (multiplier), product (unsigned product)
module arrmultip
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   inp1,
    input  logic [OP_W-1:0]   inp2,
    output logic [PROD_W-1:0] product
);
    logic [PROD_W-1:0] row [OP_W+1];
    assign row[0] = '0;
    // Each row adds the shifted partial product selected by one multiplier bit.
    for (genvar i = 0; i < OP_W; i++) begin : g_row
        assign row[i+1] = row[i] + ({{(PROD_W-OP_W){1'b0}}, inp1 & {OP_W{inp2[i]}}} << i);
    end
    assign product = row[OP_W];
endmodule

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: valid/ready burst multiply-accumulate of 4-bit operand pairs
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b/in_last (operand beats);
//        out_valid/out_ready/out_acc/out_cnt/out_ovf (burst result)
// Build option: MAC_SATURATE_EN clamps acc to all-ones on overflow; otherwise acc wraps.
module mac_accum_stage
    import mac_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);
    state_t            state_q, state_d;
    logic [OP_W-1:0]   a_q, b_q;
    logic              p_vld_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;
    logic              accept;

    arrmultip u_mult (.inp1(a_q), .inp2(b_q), .product(prod));

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign out_acc   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;
    // Extra top bit of sum is the carry that flags overflow.
    assign sum       = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (p_vld_q) begin
`ifdef MAC_SATURATE_EN
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE:    state_d = accept ? (in_last ? FLUSH : ACCUM) : IDLE;
            ACCUM:   state_d = (accept && in_last) ? FLUSH : ACCUM;
            FLUSH:   state_d = DONE;
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_vld_q <= accept;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
        end
    end
endmodule

// File: tb/tb_mac_accum_stage.sv
// tb_mac_accum_stage: scoreboard bench for mac_accum_stage (ACC_W=12, CNT_W=4)
module tb_mac_accum_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0, in_last = 0, out_ready = 0;
    logic [3:0]  in_a = 0, in_b = 0;
    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_acc;
    logic [3:0]  out_cnt;

    typedef struct {
        logic [11:0] acc;
        logic [3:0]  cnt;
        logic        ovf;
    } res_t;

    res_t sb[$];
    int   checks = 0, errors = 0;
    int   m_acc = 0, m_cnt = 0;
    bit   m_ovf = 0;

    mac_accum_stage #(.ACC_W(12), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic beat(input int a, input int b, input bit last);
        int s;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1;
        in_a = 4'(a);
        in_b = 4'(b);
        in_last = last;
        @(negedge clk);
        in_valid = 0;
        in_last = 0;
        s = m_acc + a * b;
        if (s > 4095) begin
            m_ovf = 1;
`ifdef MAC_SATURATE_EN
            s = 4095;
`else
            s = s % 4096;
`endif
        end
        m_acc = s;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (last) begin
            sb.push_back('{acc: 12'(m_acc), cnt: 4'(m_cnt), ovf: m_ovf});
            model_clear();
        end
    endtask

    task automatic bubble();
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic collect(input string nm);
        int   n = 0;
        res_t e;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b queued=%0d expected result", nm, out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (out_acc !== e.acc) begin
            errors++;
            $display("FAIL %s_acc: got %0d expected %0d", nm, out_acc, e.acc);
        end
        checks++;
        if (out_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s_cnt: got %0d expected %0d", nm, out_cnt, e.cnt);
        end
        checks++;
        if (out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s_ovf: got %b expected %b", nm, out_ovf, e.ovf);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 0 || out_cnt !== 0 || out_ovf !== 0) begin
            errors++;
            $display("FAIL %s_release: valid=%b ready=%b acc=%0d cnt=%0d ovf=%b expected 0 1 0 0 0",
                     nm, out_valid, in_ready, out_acc, out_cnt, out_ovf);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_acc !== 0 || out_cnt !== 0 || out_ovf !== 0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b acc=%0d cnt=%0d ovf=%b expected 0 1 0 0 0",
                     out_valid, in_ready, out_acc, out_cnt, out_ovf);
        end
    endtask

    task automatic test_back_to_back();
        beat(10, 12, 0);
        beat(13, 12, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_latency_early: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_latency: out_valid=%b expected 1", out_valid);
        end
        collect("b2b");
    endtask

    task automatic test_single();
        beat(15, 15, 1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_flush_ready: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done_ready: in_ready=%b expected 0", in_ready);
        end
        collect("single");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 19; i++) beat(15, 15, i == 18);
        collect("ovf");
    endtask

    task automatic test_hold();
        logic [11:0] a0;
        logic [3:0]  c0;
        logic        o0;
        beat(3, 4, 1);
        @(negedge clk);
        a0 = out_acc;
        c0 = out_cnt;
        o0 = out_ovf;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_a = 4'($urandom_range(1, 15));
            in_b = 4'($urandom_range(1, 15));
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (out_valid !== 1 || in_ready !== 0 || out_acc !== a0 || out_cnt !== c0 || out_ovf !== o0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b ready=%b acc=%0d cnt=%0d ovf=%b expected 1 0 %0d %0d %b",
                         i, out_valid, in_ready, out_acc, out_cnt, out_ovf, a0, c0, o0);
            end
        end
        in_valid = 0;
        in_last = 0;
        collect("hold");
        beat(2, 3, 1);
        collect("after_hold");
    endtask

    task automatic test_bubbles();
        beat(1, 1, 0);
        bubble();
        bubble();
        beat(2, 2, 0);
        bubble();
        beat(3, 3, 1);
        collect("bubbles");
    endtask

    task automatic test_mid_reset();
        beat(7, 7, 0);
        @(negedge clk);
        #2 rst = 1;
        #2 rst = 0;
        model_clear();
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_acc !== 0 || out_cnt !== 0 || out_ovf !== 0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b acc=%0d cnt=%0d ovf=%b expected 0 1 0 0 0",
                     out_valid, in_ready, out_acc, out_cnt, out_ovf);
        end
        @(negedge clk);
        beat(1, 1, 1);
        collect("post_reset");
    endtask

    initial begin
        #1;
        test_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_single();
        test_overflow();
        test_hold();
        test_bubbles();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
